// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/write-back bundle between the decode stage and the mul/div unit.
interface muldiv_unit_if #(parameter int DATA_WIDTH = 32) ();
    logic                  start;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [4:0]            rd_addr;
    logic                  stall;
    logic                  busy;
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    modport master (output start, funct3, rs1_data, rs2_data, rd_addr,
                    input  stall, busy, wr_en, wr_addr, wr_data);
    modport slave  (input  start, funct3, rs1_data, rs2_data, rd_addr,
                    output stall, busy, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(parameter int DATA_WIDTH = 32) (
    input logic         clk,
    input logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);
    localparam logic [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] op_q, op_d;
    logic [4:0] rd_q, rd_d, wr_addr_q, wr_addr_d;
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, wr_data_q, wr_data_d;
    logic neg_q, neg_d, rneg_q, rneg_d, busy_q;
    logic is_div, a_neg, b_neg, div0, ovf;
    logic [DW-1:0] ma, mb, quot, rem, result;
    logic [DW:0] sum, sh, diff;
    logic [2*DW-1:0] prod;
    always_comb begin
        is_div = bus.funct3[2];
        a_neg  = bus.rs1_data[DW-1] & (is_div ? ~bus.funct3[0] : (bus.funct3 == 3'd1 || bus.funct3 == 3'd2));
        b_neg  = bus.rs2_data[DW-1] & (is_div ? ~bus.funct3[0] : (bus.funct3 == 3'd1));
        ma     = a_neg ? -bus.rs1_data : bus.rs1_data;
        mb     = b_neg ? -bus.rs2_data : bus.rs2_data;
        div0   = is_div && bus.rs2_data == '0;
        ovf    = is_div && !bus.funct3[0] && bus.rs1_data == MIN && bus.rs2_data == '1;
        // hi:lo is the product accumulator for multiply and remainder:dividend/quotient for divide
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        sh     = {hi_q, lo_q[DW-1]};
        diff   = sh - {1'b0, b_q};
        prod   = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot   = neg_q ? -lo_q : lo_q;
        rem    = rneg_q ? -hi_q : hi_q;
        result = op_q[2] ? (op_q[1] ? rem : quot) : (op_q[1:0] == 2'd0 ? prod[DW-1:0] : prod[2*DW-1:DW]);
    end
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        case (state_q)
            IDLE: if (bus.start) begin
                op_d    = bus.funct3;
                rd_d    = bus.rd_addr;
                cnt_d   = CW'(DW);
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
                hi_d    = '0;
                lo_d    = is_div ? ma : mb;
                b_d     = is_div ? mb : ma;
                state_d = CALC;
                // corner cases skip iteration with the final quotient/remainder preloaded, unsigned
                if (div0 || ovf) begin
                    state_d = DONE;
                    neg_d   = 1'b0;
                    rneg_d  = 1'b0;
                    lo_d    = div0 ? '1 : MIN;
                    hi_d    = div0 ? bus.rs1_data : '0;
                end
            end
            CALC: begin
                cnt_d   = cnt_q - CW'(1);
                hi_d    = op_q[2] ? (diff[DW] ? sh[DW-1:0] : diff[DW-1:0]) : sum[DW:1];
                lo_d    = op_q[2] ? {lo_q[DW-2:0], ~diff[DW]} : {sum[0], lo_q[DW-1:1]};
                state_d = cnt_q == CW'(1) ? DONE : CALC;
            end
            DONE: begin
                state_d   = IDLE;
                wr_data_d = result;
                wr_addr_d = rd_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            busy_q    <= state_d != IDLE;
        end
    end
    assign bus.stall   = (state_q == IDLE && bus.start) || state_q == CALC;
    assign bus.busy    = busy_q;
    assign bus.wr_en   = state_q == DONE && rd_q != '0;
    assign bus.wr_addr = state_q == DONE ? rd_q : wr_addr_q;
    assign bus.wr_data = state_q == DONE ? result : wr_data_q;
endmodule
